teclado_entrada: RTL
====================

Name: teclado_entrada

Overview:
- Consumer end of the keypad scan interface: takes the 5-bit key code and per-scan detect strobe from the keypad driver and turns them into single debounced press events.
- Assembles decimal keys into an N-digit BCD entry; F (`*`) clears the entry, E (`#`) commits it, A–D issue operation codes.
- Sits between the keypad driver and the application FSM (calculator/lock) on the same 100 Hz clock.

Parameters:
- N_DIGITS, 4, number of BCD digits held in the entry buffer (1..8).
- RELEASE_CYCLES, 8, consecutive cycles with `cambio_digito`=0 required to declare release; must be ≥4 (one full column scan), max 255.

Ports:
- clk  in  1  system clock (100 Hz scan clock).
- rst  in  1  synchronous active-high reset.
- digito  in  5  key code from driver: 0–9 digits, 10–13 A–D, 14 `#`, 15 `*`, 16/17 none/invalid; meaningful only while `cambio_digito`=1.
- cambio_digito  in  1  driver strobe: high on cycles where a pressed key is detected in the scanned column.
- entrada  out  4*N_DIGITS  current entry, BCD, newest digit in bits [3:0].
- n_digitos  out  4  number of digits currently entered (0..N_DIGITS).
- valor  out  4*N_DIGITS  last committed entry; holds until the next commit.
- valor_valido  out  1  one-cycle pulse when `valor` updates.
- op  out  2  operation code: A=0, B=1, C=2, D=3; holds the last value.
- op_valido  out  1  one-cycle pulse when `op` updates.
- desborde  out  1  one-cycle pulse when a digit is pressed with the buffer full.

Behaviour:
- Reset (rst=1 at posedge): state=LIBRE, release counter=0, held key=0. All outputs are 0: entrada, n_digitos, valor, valor_valido, op, op_valido, desborde.
- Only one FSM exists; it has states LIBRE (no key held) and RETENIDA (key accepted, waiting for release).
- LIBRE:
  - When `cambio_digito`=1 and `digito`≤15, the key is accepted at that edge.
  - On acceptance: store the held key, clear the counter, go to RETENIDA, and apply the key action at the same edge. Outputs therefore reflect the action one cycle after the strobe sample.
  - `digito`≥16 with the strobe high is ignored.
- RETENIDA:
  - `cambio_digito`=1 with any code clears the counter. Other keys are ignored (no rollover).
  - Otherwise the counter increments.
  - When the counter reaches RELEASE_CYCLES the FSM goes to LIBRE at that edge. This happens on the RELEASE_CYCLES-th consecutive low cycle.
  - The next press is accepted no earlier than the following cycle.
- Key actions (exactly one per accepted press):
  - 0–9:
    - If n_digitos<N_DIGITS: `entrada` ← {entrada[4N-5:0], digit} and n_digitos+1.
    - Else: `entrada` is unchanged and `desborde` pulses.
  - 15 (`*`): entrada←0, n_digitos←0. No pulse.
  - 14 (`#`):
    - If n_digitos>0: valor←entrada, valor_valido pulses, entrada←0, n_digitos←0.
    - If n_digitos=0: ignored, no pulse.
  - 10–13: op←digito-10, op_valido pulses; the entry is unchanged.
- All pulses last exactly one cycle and are otherwise 0. At most one pulse is asserted per cycle.
- Counter width is 8 bits. It saturates at RELEASE_CYCLES and does not wrap.
- Reset while in RETENIDA returns the FSM to LIBRE. A key still held after reset is accepted as a new press on its next strobe.
- Reset has priority over all actions in the same cycle.

Test Plan:
- Press 7: strobe with digito=7 once every 4 cycles for 20 cycles, then 10 low cycles. Expect entrada=0x0007, n_digitos=1 one cycle after the first strobe, no further change while held, FSM back in LIBRE 8 cycles after the last strobe.
- Sequence 1,2,3,4,5 (each press/release) with N_DIGITS=4. Expect entrada=0x1234, n_digitos=4, and a `desborde` pulse on the 5th press.
- Press 4, 2, then `#`. Expect valor=0x0042, one `valor_valido` pulse, then entrada=0, n_digitos=0. A second `#` produces no pulse.
- Press C. Expect op=2 and a single `op_valido` pulse. While holding C, strobes with digito=5 cause no entry change; release, press `*`, and entrada clears.
- Release glitch: a gap of 7 low cycles inside one press (RELEASE_CYCLES=8) must produce only one accepted press.
- Assert rst while a key is held and 2 digits are entered. Expect all outputs 0; the continued strobe after reset is accepted as a new press.

Source files
------------

// File: rtl/teclado_entrada.sv
// ============================================================================
// Module   : teclado_entrada
// Purpose  : Keypad consumer that debounces scan strobes into single press
//            events and assembles a BCD entry with commit/clear/op keys.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module teclado_entrada #(
   parameter int N_DIGITS       = 4,
   parameter int RELEASE_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4:0]            digito,
   input  logic                  cambio_digito,
   output logic [4*N_DIGITS-1:0] entrada,
   output logic [3:0]            n_digitos,
   output logic [4*N_DIGITS-1:0] valor,
   output logic                  valor_valido,
   output logic [1:0]            op,
   output logic                  op_valido,
   output logic                  desborde
);

   localparam int         W        = 4 * N_DIGITS;
   localparam logic [0:0] LIBRE    = 1'b0;
   localparam logic [0:0] RETENIDA = 1'b1;
   localparam logic [7:0] REL      = 8'(RELEASE_CYCLES);
   localparam logic [3:0] NMAX     = 4'(N_DIGITS);

   logic [0:0]   state_q, state_d;
   logic [7:0]   cnt_q, cnt_d;
   logic [4:0]   held_q, held_d;
   logic [W-1:0] entrada_q, entrada_d;
   logic [3:0]   n_q, n_d;
   logic [W-1:0] valor_q, valor_d;
   logic         valor_valido_q, valor_valido_d;
   logic [1:0]   op_q, op_d;
   logic         op_valido_q, op_valido_d;
   logic         desborde_q, desborde_d;

   logic         accept;
   logic [3:0]   key;
   logic [W-1:0] shifted;

   // Codes 16/17 (bit 4 set) never start a press.
   assign accept = (state_q == LIBRE) && cambio_digito && !digito[4];
   assign key    = held_d[3:0];

   generate
      if (N_DIGITS == 1) begin : g_shift_one
         assign shifted = key;
      end else begin : g_shift_multi
         assign shifted = {entrada_q[W-5:0], key};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= LIBRE;
         cnt_q          <= '0;
         held_q         <= '0;
         entrada_q      <= '0;
         n_q            <= '0;
         valor_q        <= '0;
         valor_valido_q <= 1'b0;
         op_q           <= '0;
         op_valido_q    <= 1'b0;
         desborde_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         held_q         <= held_d;
         entrada_q      <= entrada_d;
         n_q            <= n_d;
         valor_q        <= valor_d;
         valor_valido_q <= valor_valido_d;
         op_q           <= op_d;
         op_valido_q    <= op_valido_d;
         desborde_q     <= desborde_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      held_d  = held_q;
      case (state_q)
         LIBRE: begin
            if (accept) begin
               state_d = RETENIDA;
               cnt_d   = '0;
               held_d  = digito;
            end
         end
         RETENIDA: begin
            if (cambio_digito) begin
               cnt_d = '0;
            end else if (cnt_q < REL) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q + 8'd1 == REL) begin
                  state_d = LIBRE;
               end
            end
         end
         default: state_d = LIBRE;
      endcase
   end

   // Key actions fire only on the accepting edge.
   always_comb begin
      entrada_d      = entrada_q;
      n_d            = n_q;
      valor_d        = valor_q;
      valor_valido_d = 1'b0;
      op_d           = op_q;
      op_valido_d    = 1'b0;
      desborde_d     = 1'b0;
      if (accept) begin
         if (key <= 4'd9) begin
            if (n_q < NMAX) begin
               entrada_d = shifted;
               n_d       = n_q + 4'd1;
            end else begin
               desborde_d = 1'b1;
            end
         end else if (key == 4'd15) begin
            entrada_d = '0;
            n_d       = '0;
         end else if (key == 4'd14) begin
            if (n_q != 4'd0) begin
               valor_d        = entrada_q;
               valor_valido_d = 1'b1;
               entrada_d      = '0;
               n_d            = '0;
            end
         end else begin
            op_d        = 2'(key - 4'd10);
            op_valido_d = 1'b1;
         end
      end
   end

   assign entrada      = entrada_q;
   assign n_digitos    = n_q;
   assign valor        = valor_q;
   assign valor_valido = valor_valido_q;
   assign op           = op_q;
   assign op_valido    = op_valido_q;
   assign desborde     = desborde_q;

endmodule

`default_nettype wire
